// File: rtl/mac_row_sequencer.sv
// Purpose : sequences a combinational multiply-add unit across an N-word row, R = A*b + C.
// Latency : 2 cycles per word; done in cycle 2N+1 (2N+2 with MAC_SEQ_CARRY_WRITE_EN); N=0 done in cycle 1.
// Backpr. : none; start is only sampled in IDLE and is dropped (not queued) while busy.
//
// Configuration macro: MAC_SEQ_CARRY_WRITE_EN -- when defined, a CARRY state writes the
// final carry word to R[N] (address wraps to 0 for a full-length row).
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   start, num_words, b_word row request; N and b latched when start is accepted in IDLE
//   rd_en, rd_addr           A/C RAM read strobe and shared address (1-cycle read latency)
//   a_rdata, c_rdata         A and C words returned by the RAMs
//   r_we, r_addr, r_wdata    R RAM write port
//   mac_x/y/z/cin            operands to the external multiply-add unit (zero outside CALC)
//   mac_s, mac_cout          low/high result words from the multiply-add unit
//   busy, done, carry_out    status, one-cycle completion pulse, final carry word
module mac_row_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [DATA_WIDTH-1:0] b_word,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  r_we,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_wdata,
  output logic [DATA_WIDTH-1:0] mac_x,
  output logic [DATA_WIDTH-1:0] mac_y,
  output logic [DATA_WIDTH-1:0] mac_z,
  output logic [DATA_WIDTH-1:0] mac_cin,
  input  logic [DATA_WIDTH-1:0] mac_s,
  input  logic [DATA_WIDTH-1:0] mac_cout,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] carry_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_CALC   = 3'd2,
`ifdef MAC_SEQ_CARRY_WRITE_EN
    S_CARRY  = 3'd3,
`endif
    S_FINISH = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH:0]   r_n;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_carry;
  logic [ADDR_WIDTH:0]   w_n_clamped;
  logic                  w_last;

  // Oversized requests collapse to a full row.
  assign w_n_clamped = (num_words > LP_MAX_N) ? LP_MAX_N : num_words;
  // idx is one bit narrower than N, so compare against N-1 in the wider domain.
  assign w_last      = ({1'b0, r_idx} == (r_n - LP_ONE));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (w_n_clamped == '0) ? S_FINISH : S_READ;
      end
      S_READ: w_state_nxt = S_CALC;
      S_CALC: begin
`ifdef MAC_SEQ_CARRY_WRITE_EN
        w_state_nxt = w_last ? S_CARRY : S_READ;
`else
        w_state_nxt = w_last ? S_FINISH : S_READ;
`endif
      end
`ifdef MAC_SEQ_CARRY_WRITE_EN
      S_CARRY: w_state_nxt = S_FINISH;
`endif
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded purely from the current state (Moore), so RAM strobes line up
  // with the cycle the state is in and the RAM data arrives exactly in CALC.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    r_we    = 1'b0;
    r_addr  = '0;
    r_wdata = '0;
    mac_x   = '0;
    mac_y   = '0;
    mac_z   = '0;
    mac_cin = '0;
    done    = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = r_idx;
      end
      S_CALC: begin
        mac_x   = a_rdata;
        mac_y   = r_b;
        mac_z   = c_rdata;
        mac_cin = r_carry;
        r_we    = 1'b1;
        r_addr  = r_idx;
        r_wdata = mac_s;
      end
`ifdef MAC_SEQ_CARRY_WRITE_EN
      S_CARRY: begin
        r_we    = 1'b1;
        r_addr  = r_n[ADDR_WIDTH-1:0];  // a full-length row wraps to address 0
        r_wdata = r_carry;
      end
`endif
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Row datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_n       <= '0;
      r_b       <= '0;
      r_carry   <= '0;
      carry_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b     <= b_word;
            r_n     <= w_n_clamped;
            r_idx   <= '0;
            r_carry <= '0;
          end
        end
        S_CALC: begin
          r_carry <= mac_cout;
          // Hold on the last word so a full-length row never wraps idx.
          if (!w_last) r_idx <= r_idx + ADDR_WIDTH'(1);
        end
        S_FINISH: carry_out <= r_carry;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_row_sequencer.sv
module tb_mac_row_sequencer;
  localparam int DW   = 64;
  localparam int AW   = 6;
  localparam int NMAX = 64;
  localparam int BIGW = DW * (NMAX + 1);
`ifdef MAC_SEQ_CARRY_WRITE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW:0]   num_words;
  logic [DW-1:0] b_word;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a_rdata;
  logic [DW-1:0] c_rdata;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] mac_x, mac_y, mac_z, mac_cin;
  logic [DW-1:0] mac_s, mac_cout;
  logic          busy;
  logic          done;
  logic [DW-1:0] carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] a_mem [NMAX];
  logic [DW-1:0] c_mem [NMAX];
  logic [DW-1:0] exp_r [NMAX+1];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];

  mac_row_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words), .b_word(b_word),
    .rd_en(rd_en), .rd_addr(rd_addr), .a_rdata(a_rdata), .c_rdata(c_rdata),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .mac_x(mac_x), .mac_y(mac_y), .mac_z(mac_z), .mac_cin(mac_cin),
    .mac_s(mac_s), .mac_cout(mac_cout),
    .busy(busy), .done(done), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational multiply-add unit beside the sequencer.
  logic [2*DW-1:0] mac_full;
  assign mac_full = {{DW{1'b0}}, mac_x} * {{DW{1'b0}}, mac_y} + {{DW{1'b0}}, mac_z} + {{DW{1'b0}}, mac_cin};
  assign mac_s    = mac_full[DW-1:0];
  assign mac_cout = mac_full[2*DW-1:DW];

  // A/C RAMs with 1-cycle read latency; R writes are logged in order.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      c_rdata <= c_mem[rd_addr];
    end
    if (r_we) begin
      wr_addr_q.push_back(r_addr);
      wr_data_q.push_back(r_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic fill_random();
    for (int i = 0; i < NMAX; i++) begin
      a_mem[i] = {$urandom, $urandom};
      c_mem[i] = {$urandom, $urandom};
    end
  endtask

  // Big-integer reference: R = A*b + C over the whole row, then split into words.
  task automatic compute_ref(input int n, input logic [DW-1:0] b);
    logic [BIGW-1:0] big_a, big_c, big_b, big_r;
    big_a = '0;
    big_c = '0;
    for (int i = 0; i < n; i++) begin
      big_a[i*DW +: DW] = a_mem[i];
      big_c[i*DW +: DW] = c_mem[i];
    end
    big_b = '0;
    big_b[DW-1:0] = b;
    big_r = big_a * big_b + big_c;
    for (int i = 0; i <= NMAX; i++) exp_r[i] = big_r[i*DW +: DW];
  endtask

  // Issues one start and runs until the done pulse (bounded). Returns the done cycle
  // (-1 on timeout), number of read strobes and number of busy cycles observed.
  // Inputs are scrambled after cycle 0 to show they are only latched at acceptance.
  task automatic run_row(input int n_in, input logic [DW-1:0] b, input int restart_cyc,
                         output int done_cyc, output int rd_cnt, output int busy_cnt);
    int cyc;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cyc = -1;
    rd_cnt   = 0;
    busy_cnt = 0;
    @(negedge clk);
    start     = 1'b1;
    num_words = n_in[AW:0];
    b_word    = b;
    @(posedge clk);
    cyc = 1;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      start     = (cyc == restart_cyc);
      b_word    = {$urandom, $urandom};
      num_words = 7'($urandom_range(0, 127));
      if (rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cyc = cyc;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    num_words = '0;
    b_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
    n_checks++; if (r_we !== 1'b0) begin n_fail++; $display("FAIL reset_r_we: got %0b expected 0", r_we); end
    n_checks++; if ({rd_addr, r_addr, r_wdata} !== '0) begin n_fail++; $display("FAIL reset_addr_data: got %0h expected 0", {rd_addr, r_addr, r_wdata}); end
    n_checks++; if ({mac_x, mac_y, mac_z, mac_cin} !== '0) begin n_fail++; $display("FAIL reset_mac: got %0h expected 0", {mac_x, mac_y, mac_z, mac_cin}); end
    n_checks++; if (carry_out !== '0) begin n_fail++; $display("FAIL reset_carry_out: got %0h expected 0", carry_out); end
  endtask

  task automatic test_single_word();
    int dc, rc, bc;
    a_mem[0] = 64'd2;
    c_mem[0] = 64'd4;
    run_row(1, 64'd3, -1, dc, rc, bc);
    n_checks++; if (dc !== 3 + EXTRA) begin n_fail++; $display("FAIL single_done_cycle: got %0d expected %0d", dc, 3 + EXTRA); end
    n_checks++; if (wr_addr_q.size() !== 1 + EXTRA) begin n_fail++; $display("FAIL single_write_count: got %0d expected %0d", wr_addr_q.size(), 1 + EXTRA); end
    n_checks++; if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 64'd10) begin n_fail++; $display("FAIL single_r0: got addr %0d data %0d expected addr 0 data 10", wr_addr_q[0], wr_data_q[0]); end
`ifdef MAC_SEQ_CARRY_WRITE_EN
    n_checks++; if (wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 64'd0) begin n_fail++; $display("FAIL single_carry_write: got addr %0d data %0h expected addr 1 data 0", wr_addr_q[1], wr_data_q[1]); end
`endif
    n_checks++; if (carry_out !== 64'd0) begin n_fail++; $display("FAIL single_carry_out: got %0h expected 0", carry_out); end
    n_checks++; if (rc !== 1 || bc !== dc) begin n_fail++; $display("FAIL single_rd_busy: got rd %0d busy %0d expected rd 1 busy %0d", rc, bc, dc); end
  endtask

  task automatic test_full_carry();
    int dc, rc, bc;
    logic [DW-1:0] ones;
    ones = '1;
    a_mem[0] = ones; a_mem[1] = ones;
    c_mem[0] = ones; c_mem[1] = ones;
    run_row(2, ones, -1, dc, rc, bc);
    n_checks++; if (dc !== 5 + EXTRA) begin n_fail++; $display("FAIL carry_done_cycle: got %0d expected %0d", dc, 5 + EXTRA); end
    n_checks++; if (wr_data_q[0] !== 64'd0) begin n_fail++; $display("FAIL carry_r0: got %0h expected 0", wr_data_q[0]); end
    n_checks++; if (wr_data_q[1] !== ones) begin n_fail++; $display("FAIL carry_r1: got %0h expected %0h", wr_data_q[1], ones); end
    n_checks++; if (carry_out !== ones) begin n_fail++; $display("FAIL carry_out_full: got %0h expected %0h", carry_out, ones); end
  endtask

  task automatic test_zero_length();
    int dc, rc, bc;
    run_row(0, 64'h1234, -1, dc, rc, bc);
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 1", dc); end
    n_checks++; if (rc !== 0 || wr_addr_q.size() !== 0) begin n_fail++; $display("FAIL zero_no_access: got rd %0d wr %0d expected 0 0", rc, wr_addr_q.size()); end
    n_checks++; if (carry_out !== 64'd0) begin n_fail++; $display("FAIL zero_carry_out: got %0h expected 0", carry_out); end
  endtask

  task automatic test_start_while_busy();
    int dc, rc, bc, extra_done, extra_busy;
    logic [DW-1:0] b;
    fill_random();
    b = {$urandom, $urandom};
    compute_ref(4, b);
    run_row(4, b, 3, dc, rc, bc);
    n_checks++; if (dc !== 9 + EXTRA) begin n_fail++; $display("FAIL busy_done_cycle: got %0d expected %0d", dc, 9 + EXTRA); end
    n_checks++; if (wr_addr_q.size() !== 4 + EXTRA) begin n_fail++; $display("FAIL busy_write_count: got %0d expected %0d", wr_addr_q.size(), 4 + EXTRA); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (wr_addr_q[k] !== k[AW-1:0] || wr_data_q[k] !== exp_r[k]) begin n_fail++; $display("FAIL busy_r%0d: got addr %0d data %0h expected addr %0d data %0h", k, wr_addr_q[k], wr_data_q[k], k, exp_r[k]); end
    end
    n_checks++; if (carry_out !== exp_r[4]) begin n_fail++; $display("FAIL busy_carry_out: got %0h expected %0h", carry_out, exp_r[4]); end
    extra_done = 0;
    extra_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    n_checks++; if (extra_done !== 0 || extra_busy !== 0) begin n_fail++; $display("FAIL busy_not_queued: got done %0d busy %0d expected 0 0", extra_done, extra_busy); end
  endtask

  task automatic test_reset_mid_row();
    int bad_we, bad_busy, bad_done, bad_out;
    logic [DW-1:0] b;
    fill_random();
    b = {$urandom, $urandom};
    compute_ref(8, b);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = 7'd8; b_word = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 7) reset = 1'b1;
      @(posedge clk);
    end
    #1 reset = 1'b0;
    bad_we = 0; bad_busy = 0; bad_done = 0; bad_out = 0;
    repeat (8) begin
      @(negedge clk);
      if (r_we !== 1'b0) bad_we++;
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if ({rd_en, rd_addr, r_addr, r_wdata, mac_x, mac_y, mac_z, mac_cin, carry_out} !== '0) bad_out++;
    end
    n_checks++; if (bad_we !== 0) begin n_fail++; $display("FAIL rst_r_we: got %0d write cycles expected 0", bad_we); end
    n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL rst_busy: got %0d busy cycles expected 0", bad_busy); end
    n_checks++; if (bad_done !== 0) begin n_fail++; $display("FAIL rst_done: got %0d done pulses expected 0", bad_done); end
    n_checks++; if (bad_out !== 0) begin n_fail++; $display("FAIL rst_outputs: got %0d non-reset cycles expected 0", bad_out); end
    n_checks++; if (wr_addr_q.size() !== 3) begin n_fail++; $display("FAIL rst_write_count: got %0d expected 3", wr_addr_q.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (wr_data_q[k] !== exp_r[k]) begin n_fail++; $display("FAIL rst_r%0d: got %0h expected %0h", k, wr_data_q[k], exp_r[k]); end
    end
  endtask

  // Rows issued back-to-back (start in the cycle after done), including a full-length
  // row and an oversized request that must behave as a full-length row.
  task automatic test_back_to_back();
    int n_list [5] = '{3, 64, 1, 100, 7};
    int dc, rc, bc, n_eff, werr;
    logic [DW-1:0] b;
    for (int r = 0; r < 5; r++) begin
      n_eff = (n_list[r] > NMAX) ? NMAX : n_list[r];
      fill_random();
      b = {$urandom, $urandom};
      compute_ref(n_eff, b);
      run_row(n_list[r], b, -1, dc, rc, bc);
      n_checks++; if (dc !== 2 * n_eff + 1 + EXTRA) begin n_fail++; $display("FAIL b2b_done_cycle row %0d: got %0d expected %0d", r, dc, 2 * n_eff + 1 + EXTRA); end
      n_checks++; if (bc !== dc || rc !== n_eff) begin n_fail++; $display("FAIL b2b_busy_rd row %0d: got busy %0d rd %0d expected busy %0d rd %0d", r, bc, rc, dc, n_eff); end
      n_checks++; if (wr_addr_q.size() !== n_eff + EXTRA) begin n_fail++; $display("FAIL b2b_write_count row %0d: got %0d expected %0d", r, wr_addr_q.size(), n_eff + EXTRA); end
      werr = 0;
      for (int k = 0; k < n_eff; k++) begin
        if (wr_addr_q[k] !== k[AW-1:0] || wr_data_q[k] !== exp_r[k]) werr++;
      end
      n_checks++; if (werr !== 0) begin n_fail++; $display("FAIL b2b_row_words row %0d: got %0d wrong words expected 0", r, werr); end
`ifdef MAC_SEQ_CARRY_WRITE_EN
      n_checks++; if (wr_addr_q[n_eff] !== n_eff[AW-1:0] || wr_data_q[n_eff] !== exp_r[n_eff]) begin n_fail++; $display("FAIL b2b_carry_write row %0d: got addr %0d data %0h expected addr %0d data %0h", r, wr_addr_q[n_eff], wr_data_q[n_eff], n_eff[AW-1:0], exp_r[n_eff]); end
`endif
      n_checks++; if (carry_out !== exp_r[n_eff]) begin n_fail++; $display("FAIL b2b_carry_out row %0d: got %0h expected %0h", r, carry_out, exp_r[n_eff]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_words = '0;
    b_word = '0;
    test_reset();
    test_single_word();
    test_full_carry();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_row();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_row_sequencer.md
# mac_row_sequencer

Word-serial controller that sequences a combinational 64-bit multiply-add unit (x*y + z + cin -> {cout, s}) across a multi-word operand row. It computes R = A*b + C for an N-word A and C and a single-word b, with carry propagation between words. It is the inner-row engine of the RSA Montgomery/schoolbook multiplier. A, C and R live in synchronous word RAMs outside the block, and the multiply-add unit is instantiated beside it and wired through the mac_* ports.

## Interface
Parameters:
- DATA_WIDTH, 64, word width of operands and of the multiply-add unit
- ADDR_WIDTH, 6, word-address width; maximum row length is 2**ADDR_WIDTH words

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a row operation; sampled only in IDLE
- num_words  in  ADDR_WIDTH+1  row length N, legal range 0..2**ADDR_WIDTH; larger values are treated as 2**ADDR_WIDTH
- b_word  in  DATA_WIDTH  scalar multiplier, latched on start acceptance
- rd_en  out  1  read strobe to the A and C RAMs
- rd_addr  out  ADDR_WIDTH  shared read address for the A and C RAMs
- a_rdata  in  DATA_WIDTH  A word, valid the cycle after rd_en
- c_rdata  in  DATA_WIDTH  C word, valid the cycle after rd_en
- r_we  out  1  write strobe to the R RAM
- r_addr  out  ADDR_WIDTH  R write address
- r_wdata  out  DATA_WIDTH  R write data
- mac_x, mac_y, mac_z, mac_cin  out  DATA_WIDTH each  operands to the multiply-add unit
- mac_s, mac_cout  in  DATA_WIDTH each  low and high result words from the multiply-add unit
- busy  out  1  high from the cycle after start acceptance until the return to IDLE
- done  out  1  one-cycle completion pulse
- carry_out  out  DATA_WIDTH  final carry word; holds its value until the next start is accepted

## Operation
- FSM states: IDLE, READ, CALC, CARRY, FINISH.
- **IDLE**
  - When start=1: latch b_word and N, clear idx and the carry register.
  - Go to FINISH if N=0, otherwise go to READ.
- **READ**
  - Drive rd_en=1 and rd_addr=idx.
  - Go to CALC.
- **CALC**
  - Drive mac_x=a_rdata, mac_y=b_reg, mac_z=c_rdata, mac_cin=carry.
  - Drive r_we=1, r_addr=idx, r_wdata=mac_s.
  - On the clock edge: carry <= mac_cout and idx <= idx+1.
  - If idx == N-1, go to CARRY (macro defined) or FINISH (macro undefined). Otherwise go to READ.
- **CARRY** (exists only when the macro is defined)
  - Drive r_we=1, r_addr=N[ADDR_WIDTH-1:0], r_wdata=carry.
  - Go to FINISH.
- **FINISH**
  - Drive done=1 and load carry_out from the carry register.
  - Go to IDLE.
- Default values: mac_* outputs are 0 outside CALC. rd_en and r_we are 0 except in the states listed above.
- Arithmetic: no overflow is possible, because (2^W-1)^2 + 2(2^W-1) = 2^2W - 1.
- start is ignored in every state other than IDLE. It is not queued.
- idx does not wrap: N=2**ADDR_WIDTH ends at idx=2**ADDR_WIDTH-1.
- Reset values:
  - state=IDLE
  - busy, done, rd_en, r_we = 0
  - rd_addr, r_addr, r_wdata, mac_*, carry_out, carry, idx, b_reg = 0
- Reset takes priority over everything, including mid-row. A write in progress in that cycle is suppressed (r_we=0 the following cycle), and no done pulse is issued.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Read latency of the RAMs is exactly 1 cycle.
- Each word costs 2 cycles (READ then CALC). The multiply-add unit is combinational within CALC.
- Without the macro, done is high in cycle 2N+1. busy is high in cycles 1..2N+1.
- With the macro, done is high in cycle 2N+2. busy is high in cycles 1..2N+2.
- With N=0 and no macro, done is high in cycle 1 and no reads or writes occur. carry_out=0.
- A new start is accepted at the earliest in the cycle after done (back-to-back rows with one idle cycle).

## Configuration
- Macro: MAC_SEQ_CARRY_WRITE_EN.
- Defined: the CARRY state exists and the final carry is written to R[N]. This adds 1 cycle of latency.
  - With N=2**ADDR_WIDTH the write lands at address 0; the system must size R for this case.
- Undefined: the CARRY state is absent, and the final carry is available only on carry_out.

## Test plan
- **Single word:** N=1, a[0]=2, b=3, c[0]=4 -> r[0]=10, carry_out=0, done in cycle 3 (4 with the macro; R[1]=0 is written).
- **Full carry chain:** N=2, a[*]=b=c[*]=0xFFFF_FFFF_FFFF_FFFF.
  - Expect r[0]=0 and r[1]=0xFFFF_FFFF_FFFF_FFFF.
  - Expect carry_out=0xFFFF_FFFF_FFFF_FFFF.
- **Zero length:** N=0 -> done in cycle 1, rd_en and r_we never asserted, carry_out=0.
- **Start while busy:** N=4 with start pulsed again in cycle 3 -> exactly 4 writes occur, then a single done pulse. A second row starts only if start is reasserted after done.
- **Reset mid-row:** N=8 with reset in cycle 7 -> r_we=0 from cycle 8 on, no done pulse, busy=0. All outputs hold their reset values until the next start.
- **Maximum length:** N=64 with random a, c, b -> 64 writes to addresses 0..63 in order. Results match a bench big-integer reference. done occurs in cycle 129 (130 with the macro).
